coreuart_model: RTL and testbench

Synthesizable, parametrised behavioural model of the CoreUART parallel-side interface, used in place of the real UART in simulation and FPGA loopback builds. It accepts transmit bytes with a CoreUART-style busy window and delivers receive bytes through an RX FIFO. Receive bytes come either from an on-chip LFSR generator with pseudo-random inter-byte gaps, or from looped-back TX bytes. The echo datapath sits on the UART side and sees only rxrdy/txrdy/oen/wen/data.

---
 rtl/coreuart_model.sv | 137 +++++++++++++
 tb/tb_coreuart_model.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/coreuart_model.sv
// Behavioural stand-in for the CoreUART parallel interface: TX busy window, RX FIFO,
// and RX bytes sourced from either an LFSR generator or looped-back TX bytes.
module coreuart_model #(
   parameter int          DATA_W        = 8,
   parameter int          TX_CYCLES     = 11,
   parameter int          RX_FIFO_DEPTH = 4,
   parameter int          RX_DELAY_MIN  = 1000,
   parameter int          RX_DELAY_SPAN = 1024,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              oen,
   input  logic              wen,
   input  logic [DATA_W-1:0] data_in,
   input  logic              loopback,
   output logic              rxrdy,
   output logic              txrdy,
   output logic [DATA_W-1:0] data_out,
   output logic              overflow,
   output logic              tx_valid,
   output logic [DATA_W-1:0] tx_data
);
   localparam int          AW        = $clog2(RX_FIFO_DEPTH);
   localparam int          TW        = $clog2(TX_CYCLES + 1);
   localparam int          CW        = $clog2(RX_DELAY_MIN + RX_DELAY_SPAN);
   localparam logic [15:0] SPAN_MASK = 16'(RX_DELAY_SPAN - 1);

   typedef enum logic {IDLE, BUSY} tx_state_t;

   tx_state_t         state;
   logic [TW-1:0]     tx_count;
   logic              wen_q, oen_q;
   logic [15:0]       lfsr;
   logic [CW-1:0]     gap_count;
   logic [DATA_W-1:0] mem [RX_FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       occupancy;

   logic              wen_fall, oen_fall, tx_done, gen_fire;
   logic              push, pop, push_ok, full, empty;
   logic [DATA_W-1:0] push_data;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic logic [CW-1:0] gap_of(input logic [15:0] l);
      return CW'(RX_DELAY_MIN) + CW'(l & SPAN_MASK);
   endfunction

   assign wen_fall  = wen_q & ~wen;
   assign oen_fall  = oen_q & ~oen;
   assign tx_done   = (state == BUSY) && (tx_count == TW'(1));
   assign gen_fire  = !loopback && (gap_count == CW'(1));
   assign push      = (tx_done && loopback) || gen_fire;
   assign push_data = loopback ? tx_data : lfsr[DATA_W-1:0];
   assign empty     = (occupancy == '0);
   assign full      = (occupancy == (AW+1)'(RX_FIFO_DEPTH));
   assign pop       = oen_fall && !empty;
   // a full FIFO still accepts a push when the same cycle frees a slot
   assign push_ok   = push && (!full || pop);
   assign rxrdy     = !empty;
   assign data_out  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tx_count <= '0;
         txrdy    <= 1'b1;
         tx_valid <= 1'b0;
         tx_data  <= '0;
         wen_q    <= 1'b1;
         oen_q    <= 1'b1;
      end else begin
         wen_q    <= wen;
         oen_q    <= oen;
         tx_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (wen_fall) begin
                  state    <= BUSY;
                  tx_count <= TW'(TX_CYCLES);
                  txrdy    <= 1'b0;
                  tx_valid <= 1'b1;
                  tx_data  <= data_in;
               end
            end
            BUSY: begin
               if (tx_count == TW'(1)) begin
                  state    <= IDLE;
                  txrdy    <= 1'b1;
                  tx_count <= '0;
               end else begin
                  tx_count <= tx_count - TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // generator: counter and LFSR freeze while loopback is selected
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr      <= LFSR_SEED;
         gap_count <= gap_of(LFSR_SEED);
      end else if (gen_fire) begin
         lfsr      <= lfsr_step(lfsr);
         gap_count <= gap_of(lfsr_step(lfsr));
      end else if (!loopback) begin
         gap_count <= gap_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         overflow  <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   occupancy <= occupancy + (AW+1)'(1);
            2'b01:   occupancy <= occupancy - (AW+1)'(1);
            default: occupancy <= occupancy;
         endcase
         if (push && full && !pop) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_coreuart_model.sv
// Directed bench for coreuart_model: generator timing, TX window, loopback FIFO,
// overflow, full-with-read, and reset during a busy TX.
module tb_coreuart_model;
   logic       clk = 1'b0;
   logic       rst, oen, wen, loopback;
   logic [7:0] data_in;
   logic       rxrdy, txrdy, overflow, tx_valid;
   logic [7:0] data_out, tx_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int r, p, low;

   coreuart_model dut (
      .clk(clk), .rst(rst), .oen(oen), .wen(wen), .data_in(data_in),
      .loopback(loopback), .rxrdy(rxrdy), .txrdy(txrdy), .data_out(data_out),
      .overflow(overflow), .tx_valid(tx_valid), .tx_data(tx_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      data_in = b;
      wen = 1'b0;
      tick();
      wen = 1'b1;
      n = 0;
      while (!txrdy && n < 40) begin
         tick();
         n++;
      end
      check("tx_done", {31'd0, txrdy}, 32'd1);
   endtask

   task automatic pop_byte();
      oen = 1'b0;
      tick();
      oen = 1'b1;
      tick();
   endtask

   initial begin
      rst = 1'b1; oen = 1'b1; wen = 1'b1; loopback = 1'b0; data_in = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rxrdy", {31'd0, rxrdy}, 32'd0);
      check("rst_txrdy", {31'd0, txrdy}, 32'd1);
      check("rst_data_out", {24'd0, data_out}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      rst = 1'b0;
      r = cyc;

      // first generated byte: gap 1000 + (ACE1 & 3FF) = 1225, byte E1
      for (int n = 0; n < 1300 && !rxrdy; n++) tick();
      check("gen_gap0", cyc - r, 32'd1225);
      check("gen_byte0", {24'd0, data_out}, 32'hE1);
      p = cyc;
      pop_byte();
      check("gen_pop0_empty", {31'd0, rxrdy}, 32'd0);
      check("gen_pop0_data", {24'd0, data_out}, 32'd0);

      // LFSR advances to 59C3: gap 1000 + 1C3 = 1451, byte C3
      for (int n = 0; n < 1600 && !rxrdy; n++) tick();
      check("gen_gap1", cyc - p, 32'd1451);
      check("gen_byte1", {24'd0, data_out}, 32'hC3);
      pop_byte();
      check("gen_pop1_empty", {31'd0, rxrdy}, 32'd0);

      // TX window with loopback off, plus an ignored wen fall while busy
      data_in = 8'h5A;
      wen = 1'b0;
      tick();
      wen = 1'b1;
      check("tx_valid_pulse", {31'd0, tx_valid}, 32'd1);
      check("tx_data_cap", {24'd0, tx_data}, 32'h5A);
      check("tx_busy_start", {31'd0, txrdy}, 32'd0);
      low = 1;
      for (int i = 0; i < 20; i++) begin
         if (i == 3) begin
            data_in = 8'hA5;
            wen = 1'b0;
         end
         tick();
         wen = 1'b1;
         if (i == 0) check("tx_valid_one_cycle", {31'd0, tx_valid}, 32'd0);
         if (i == 3) begin
            check("busy_wen_no_pulse", {31'd0, tx_valid}, 32'd0);
            check("busy_wen_no_capture", {24'd0, tx_data}, 32'h5A);
         end
         if (!txrdy) low++;
         else break;
      end
      check("tx_low_cycles", low, 32'd11);
      check("tx_no_loop_push", {31'd0, rxrdy}, 32'd0);

      // loopback ordering
      loopback = 1'b1;
      tick();
      send_byte(8'h11);
      check("lb_rxrdy", {31'd0, rxrdy}, 32'd1);
      check("lb_head0", {24'd0, data_out}, 32'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      check("lb_head_kept", {24'd0, data_out}, 32'h11);
      pop_byte();
      check("lb_pop1", {24'd0, data_out}, 32'h22);
      pop_byte();
      check("lb_pop2", {24'd0, data_out}, 32'h33);
      pop_byte();
      check("lb_pop3_empty", {31'd0, rxrdy}, 32'd0);
      pop_byte();
      check("lb_pop_empty_ignored", {31'd0, rxrdy}, 32'd0);

      // overflow: fifth byte dropped
      for (int i = 1; i <= 4; i++) send_byte(8'hA0 + 8'(i));
      check("ovf_before", {31'd0, overflow}, 32'd0);
      send_byte(8'hA5);
      check("ovf_after", {31'd0, overflow}, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         check("ovf_read", {24'd0, data_out}, 32'hA0 + i);
         pop_byte();
      end
      check("ovf_read_empty", {31'd0, rxrdy}, 32'd0);

      // reset asserted at busy cycle 5
      data_in = 8'h77;
      wen = 1'b0;
      tick();
      wen = 1'b1;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      check("mid_rst_txrdy", {31'd0, txrdy}, 32'd1);
      check("mid_rst_rxrdy", {31'd0, rxrdy}, 32'd0);
      check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
      check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
      rst = 1'b0;
      repeat (15) tick();
      check("mid_rst_no_push", {31'd0, rxrdy}, 32'd0);

      // full FIFO with a read on the push edge
      for (int i = 1; i <= 4; i++) send_byte(8'hB0 + 8'(i));
      data_in = 8'hB5;
      wen = 1'b0;
      tick();
      wen = 1'b1;
      repeat (10) tick();
      oen = 1'b0;
      tick();
      oen = 1'b1;
      check("full_rw_overflow", {31'd0, overflow}, 32'd0);
      check("full_rw_txrdy", {31'd0, txrdy}, 32'd1);
      check("full_rw_head", {24'd0, data_out}, 32'hB2);
      tick();
      for (int i = 3; i <= 5; i++) begin
         pop_byte();
         check("full_rw_read", {24'd0, data_out}, 32'hB0 + i);
      end
      pop_byte();
      check("full_rw_empty", {31'd0, rxrdy}, 32'd0);
      check("full_rw_overflow_end", {31'd0, overflow}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
